// File: rtl/enemy_wave_if.sv
// Connects enemy_wave_ctrl to the game logic and the shared path ROM.
// The master side drives game control and ROM data; the slave side is the controller.
`timescale 1ns/1ps
interface enemy_wave_if;
  logic        start;
  logic [3:0]  kill;
  logic [11:0] rom_addr;
  logic [11:0] rom_x;
  logic [11:0] rom_y;
  logic [43:0] en_x;
  logic [43:0] en_y;
  logic [3:0]  alive;
  logic [3:0]  level;
  logic        pos_valid;
  logic        level_done;
  logic        game_won;
  logic        busy;

  modport master (
    output start, kill, rom_x, rom_y,
    input  rom_addr, en_x, en_y, alive, level, pos_valid, level_done, game_won, busy
  );

  modport slave (
    input  start, kill, rom_x, rom_y,
    output rom_addr, en_x, en_y, alive, level, pos_valid, level_done, game_won, busy
  );
endinterface

// File: rtl/enemy_wave_ctrl.sv
// Enemy wave controller: four enemies walk a per-level path stored in a shared ROM.
// Every TICK_LIMIT cycles the positions of all four enemies are re-read from the ROM
// in a fixed five-cycle fetch, then the path offset advances by one entry.
// Killing all enemies advances the level; clearing MAX_LEVEL wins the game.
`timescale 1ns/1ps
module enemy_wave_ctrl #(
  parameter int TICK_LIMIT   = 1000000,
  parameter int LEVEL_SCALER = 150,
  parameter int SPACING      = 30,
  parameter int MAX_LEVEL    = 2
) (
  input logic         pclk,
  input logic         rst,
  enemy_wave_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RUN      = 3'd1,
    FETCH    = 3'd2,
    LEVEL_UP = 3'd3,
    WON      = 3'd4
  } state_t;

  localparam logic [20:0] TICK_LAST  = 21'(TICK_LIMIT - 1);
  localparam logic [11:0] SCALER12   = 12'(LEVEL_SCALER);
  localparam logic [11:0] SPACING12  = 12'(SPACING);
  localparam logic [7:0]  OFF_LAST   = 8'(LEVEL_SCALER - 1);
  localparam logic [3:0]  LEVEL_LAST = 4'(MAX_LEVEL);

  state_t      state;
  state_t      state_next;
  logic [20:0] tick_cnt;
  logic [7:0]  off;
  logic [2:0]  phase;       // fetch sub-cycle F0..F4
  logic [3:0]  level;
  logic [3:0]  alive;
  logic [11:0] rom_addr;
  logic [10:0] pos_x [4];
  logic [10:0] pos_y [4];
  logic        pos_valid;
  logic        level_done;
  logic        game_won;

  logic        tick_hit;
  logic        load_addr;   // rom_addr takes a new enemy address at this edge
  logic [1:0]  addr_slot;   // enemy whose address is requested
  logic [11:0] addr_next;
  logic [1:0]  cap_slot;    // enemy whose ROM data is on rom_x/rom_y this cycle
  logic        unused_rom_msb;

  // Path address of enemy k: level base plus (off + k*SPACING) folded into one level.
  // A single conditional subtract is enough since the sum never reaches 2*LEVEL_SCALER.
  function automatic logic [11:0] path_addr(input logic [3:0] lvl,
                                            input logic [7:0] o,
                                            input logic [1:0] k);
    logic [11:0] step_sum;
    logic [11:0] base;
    step_sum = {4'd0, o} + ({10'd0, k} * SPACING12);
    if (step_sum >= SCALER12) step_sum = step_sum - SCALER12;
    base = SCALER12 * ({8'd0, lvl} - 12'd1);
    return base + step_sum;
  endfunction

  assign tick_hit  = (tick_cnt == TICK_LAST);
  assign addr_next = path_addr(level, off, addr_slot);
  assign cap_slot  = 2'(phase - 3'd1);

  // ROM data is 11-bit screen coordinates; the top bit of each word is not used.
  assign unused_rom_msb = ^{bus.rom_x[11], bus.rom_y[11]};

  // Next-state decode and the address request that starts each fetch sub-cycle.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can hold an old value (no latch).
    state_next = state;
    load_addr  = 1'b0;
    addr_slot  = 2'd0;
    case (state)
      IDLE, WON: begin
        if (bus.start) state_next = RUN;
      end
      RUN: begin
        // An empty wave must level up even if the step timer expires in the same cycle.
        if (alive == 4'd0) begin
          state_next = LEVEL_UP;
        end else if (tick_hit) begin
          state_next = FETCH;
          load_addr  = 1'b1;
          addr_slot  = 2'd0;
        end
      end
      FETCH: begin
        // F0..F2 request the next enemy; the address for enemy 0 was loaded on entry.
        if (phase < 3'd3) begin
          load_addr = 1'b1;
          addr_slot = 2'(phase + 3'd1);
        end
        if (phase == 3'd4) state_next = RUN;
      end
      LEVEL_UP: begin
        state_next = (level < LEVEL_LAST) ? RUN : WON;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge pclk) begin
    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values together.
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Datapath: step timer, path offset, fetch phase, level/alive bookkeeping, positions, pulses.
  always_ff @(posedge pclk) begin
    if (rst) begin
      tick_cnt   <= '0;
      off        <= '0;
      phase      <= '0;
      level      <= '0;
      alive      <= '0;
      rom_addr   <= '0;
      pos_valid  <= 1'b0;
      level_done <= 1'b0;
      game_won   <= 1'b0;
      // NOTE: the position slots drive outputs directly, so they are cleared like any other flop rather than left as uninitialised storage.
      for (int k = 0; k < 4; k++) begin
        pos_x[k] <= '0;
        pos_y[k] <= '0;
      end
    end else begin
      pos_valid  <= 1'b0;
      level_done <= 1'b0;
      game_won   <= 1'b0;
      if (load_addr) rom_addr <= addr_next;

      case (state)
        IDLE, WON: begin
          if (bus.start) begin
            level    <= 4'd1;
            alive    <= 4'hF;
            off      <= '0;
            tick_cnt <= '0;
            phase    <= '0;
          end
        end
        RUN: begin
          alive <= alive & ~bus.kill;
          if (alive != 4'd0) begin
            if (tick_hit) begin
              tick_cnt <= '0;
              phase    <= '0;
            end else begin
              tick_cnt <= tick_cnt + 21'd1;
            end
          end
        end
        FETCH: begin
          // Kills land immediately, but the fetch always refreshes all four slots.
          alive <= alive & ~bus.kill;
          if (phase != 3'd0) begin
            pos_x[cap_slot] <= bus.rom_x[10:0];
            pos_y[cap_slot] <= bus.rom_y[10:0];
          end
          if (phase == 3'd4) begin
            phase     <= '0;
            pos_valid <= 1'b1;
            off       <= (off == OFF_LAST) ? 8'd0 : off + 8'd1;
          end else begin
            phase <= phase + 3'd1;
          end
        end
        LEVEL_UP: begin
          if (level < LEVEL_LAST) begin
            level      <= level + 4'd1;
            alive      <= 4'hF;
            off        <= '0;
            tick_cnt   <= '0;
            level_done <= 1'b1;
          end else begin
            // Final level cleared: level, alive and positions stay as they are.
            game_won <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.rom_addr   = rom_addr;
  assign bus.en_x       = {pos_x[3], pos_x[2], pos_x[1], pos_x[0]};
  assign bus.en_y       = {pos_y[3], pos_y[2], pos_y[1], pos_y[0]};
  assign bus.alive      = alive;
  assign bus.level      = level;
  assign bus.pos_valid  = pos_valid;
  assign bus.level_done = level_done;
  assign bus.game_won   = game_won;
  assign bus.busy       = (state != IDLE) && (state != WON);

endmodule

// File: tb/tb_enemy_wave_ctrl.sv
// Directed bench for enemy_wave_ctrl with TICK_LIMIT=10 and a one-cycle-latency
// path ROM holding x[a]=a, y[a]=a+512.
`timescale 1ns/1ps
module tb_enemy_wave_ctrl;

  logic pclk = 1'b0;
  logic rst  = 1'b1;
  int   assertions = 0;
  int   failures   = 0;

  enemy_wave_if bus();

  enemy_wave_ctrl #(
    .TICK_LIMIT  (10),
    .LEVEL_SCALER(150),
    .SPACING     (30),
    .MAX_LEVEL   (2)
  ) dut (
    .pclk(pclk),
    .rst (rst),
    .bus (bus)
  );

  always #5 pclk = ~pclk;

  // Path ROM: data for an address appears one cycle after the address is presented.
  always @(posedge pclk) begin
    bus.rom_x <= bus.rom_addr;
    bus.rom_y <= bus.rom_addr + 12'd512;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  // Reference path address, using a true modulo rather than the design's subtract.
  function automatic int exp_addr(input int lvl, input int o, input int k);
    return 150 * (lvl - 1) + ((o + 30 * k) % 150);
  endfunction

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  // One full path step from the first RUN cycle (counter 0): 10 RUN cycles, 5 fetch cycles.
  // k2/k3 are kill vectors applied during F2 and F3; poke_start pulses start in RUN.
  task automatic do_step(input int lvl, input int o, input logic [3:0] k2,
                         input logic [3:0] k3, input logic poke_start);
    logic [11:0] got [4];
    int          ea;
    if (poke_start) bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    assertions++;
    if (bus.pos_valid !== 1'b0 || bus.level_done !== 1'b0) begin
      failures++;
      $display("FAIL step_pulse_width: got pos_valid=%0b level_done=%0b, required 0/0", bus.pos_valid, bus.level_done);
    end
    repeat (8) tick();
    tick(); got[0] = bus.rom_addr;              // entered F0
    tick(); got[1] = bus.rom_addr;              // entered F1
    tick(); got[2] = bus.rom_addr;              // entered F2
    bus.kill = k2;
    tick(); got[3] = bus.rom_addr;              // entered F3
    bus.kill = k3;
    tick();                                     // entered F4
    bus.kill = 4'd0;
    assertions++;
    if (bus.pos_valid !== 1'b0) begin
      failures++;
      $display("FAIL step_pos_valid_early: got %0b, required 0", bus.pos_valid);
    end
    tick();                                     // back in RUN
    assertions++;
    if (bus.pos_valid !== 1'b1) begin
      failures++;
      $display("FAIL step_pos_valid: got %0b, required 1 (level %0d off %0d)", bus.pos_valid, lvl, o);
    end
    for (int k = 0; k < 4; k++) begin
      ea = exp_addr(lvl, o, k);
      assertions++;
      if (got[k] !== 12'(ea)) begin
        failures++;
        $display("FAIL step_rom_addr[%0d]: got %0d, required %0d (level %0d off %0d)", k, got[k], ea, lvl, o);
      end
      assertions++;
      if (bus.en_x[11*k +: 11] !== 11'(ea) || bus.en_y[11*k +: 11] !== 11'(ea + 512)) begin
        failures++;
        $display("FAIL step_pos[%0d]: got x=%0d y=%0d, required x=%0d y=%0d", k,
                 bus.en_x[11*k +: 11], bus.en_y[11*k +: 11], ea, ea + 512);
      end
    end
  endtask

  task automatic test_reset();
    bus.start = 1'b1;
    bus.kill  = 4'hF;
    rst = 1'b1;
    tick();
    tick();
    assertions++;
    if (bus.rom_addr !== 12'd0 || bus.en_x !== 44'd0 || bus.en_y !== 44'd0) begin
      failures++;
      $display("FAIL reset_data: got addr=%0d x=%0h y=%0h, required all 0", bus.rom_addr, bus.en_x, bus.en_y);
    end
    assertions++;
    if ({bus.alive, bus.level, bus.pos_valid, bus.level_done, bus.game_won, bus.busy} !== 12'd0) begin
      failures++;
      $display("FAIL reset_status: got alive=%0h level=%0d pulses=%0b%0b%0b busy=%0b, required all 0",
               bus.alive, bus.level, bus.pos_valid, bus.level_done, bus.game_won, bus.busy);
    end
    rst = 1'b0;
    bus.start = 1'b0;
    bus.kill  = 4'd0;
    tick();
    assertions++;
    if (bus.busy !== 1'b0 || bus.level !== 4'd0) begin
      failures++;
      $display("FAIL reset_start_ignored: got busy=%0b level=%0d, required 0/0", bus.busy, bus.level);
    end
  endtask

  task automatic test_first_fetch();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    assertions++;
    if (bus.busy !== 1'b1 || bus.level !== 4'd1 || bus.alive !== 4'hF) begin
      failures++;
      $display("FAIL start_state: got busy=%0b level=%0d alive=%0h, required 1/1/f", bus.busy, bus.level, bus.alive);
    end
    do_step(1, 0, 4'd0, 4'd0, 1'b0);
  endtask

  task automatic test_wrap();
    int o = 1;
    for (int s = 0; s < 150; s++) begin
      do_step(1, o, 4'd0, 4'd0, 1'b0);
      o = (o + 1) % 150;
    end
  endtask

  task automatic test_kill_during_fetch();
    do_step(1, 1, 4'b0010, 4'b0010, 1'b0);
    assertions++;
    if (bus.alive !== 4'hD) begin
      failures++;
      $display("FAIL fetch_kill_alive: got %0h, required d", bus.alive);
    end
  endtask

  task automatic test_start_ignored();
    do_step(1, 2, 4'd0, 4'd0, 1'b1);
    assertions++;
    if (bus.level !== 4'd1 || bus.alive !== 4'hD) begin
      failures++;
      $display("FAIL run_start_ignored: got level=%0d alive=%0h, required 1/d", bus.level, bus.alive);
    end
  endtask

  task automatic test_level_up();
    bus.kill = 4'hF;
    tick();
    bus.kill = 4'd0;
    assertions++;
    if (bus.alive !== 4'h0 || bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL kill_all: got alive=%0h busy=%0b, required 0/1", bus.alive, bus.busy);
    end
    tick();                                     // RUN sees empty wave, enters LEVEL_UP
    assertions++;
    if (bus.level !== 4'd1 || bus.level_done !== 1'b0) begin
      failures++;
      $display("FAIL level_up_entry: got level=%0d level_done=%0b, required 1/0", bus.level, bus.level_done);
    end
    tick();
    assertions++;
    if (bus.level !== 4'd2 || bus.alive !== 4'hF || bus.level_done !== 1'b1 || bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL level_up: got level=%0d alive=%0h level_done=%0b busy=%0b, required 2/f/1/1",
               bus.level, bus.alive, bus.level_done, bus.busy);
    end
    do_step(2, 0, 4'd0, 4'd0, 1'b0);
  endtask

  task automatic test_won();
    repeat (8) tick();                          // counter reaches 8
    bus.kill = 4'hF;
    tick();                                     // alive=0, counter=9
    bus.kill = 4'd0;
    tick();                                     // empty wave wins over the expiring step timer
    assertions++;
    if (bus.rom_addr !== 12'd240 || bus.busy !== 1'b1 || bus.game_won !== 1'b0) begin
      failures++;
      $display("FAIL empty_priority: got addr=%0d busy=%0b game_won=%0b, required 240/1/0",
               bus.rom_addr, bus.busy, bus.game_won);
    end
    tick();
    assertions++;
    if (bus.game_won !== 1'b1 || bus.busy !== 1'b0 || bus.level !== 4'd2 || bus.level_done !== 1'b0) begin
      failures++;
      $display("FAIL game_won: got game_won=%0b busy=%0b level=%0d level_done=%0b, required 1/0/2/0",
               bus.game_won, bus.busy, bus.level, bus.level_done);
    end
    assertions++;
    if (bus.alive !== 4'h0 || bus.en_x[43:33] !== 11'd240 || bus.en_y[10:0] !== 11'd662) begin
      failures++;
      $display("FAIL won_hold: got alive=%0h x3=%0d y0=%0d, required 0/240/662",
               bus.alive, bus.en_x[43:33], bus.en_y[10:0]);
    end
    tick();
    assertions++;
    if (bus.game_won !== 1'b0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL won_pulse_width: got game_won=%0b busy=%0b, required 0/0", bus.game_won, bus.busy);
    end
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    assertions++;
    if (bus.level !== 4'd1 || bus.alive !== 4'hF || bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL restart: got level=%0d alive=%0h busy=%0b, required 1/f/1", bus.level, bus.alive, bus.busy);
    end
  endtask

  task automatic test_reset_in_fetch();
    repeat (9) tick();
    tick();                                     // F0
    tick();                                     // F1
    tick();                                     // F2
    assertions++;
    if (bus.rom_addr !== 12'd60) begin
      failures++;
      $display("FAIL prereset_addr: got %0d, required 60", bus.rom_addr);
    end
    rst = 1'b1;
    bus.start = 1'b1;
    bus.kill  = 4'hF;
    tick();
    rst = 1'b0;
    bus.start = 1'b0;
    bus.kill  = 4'd0;
    assertions++;
    if (bus.rom_addr !== 12'd0 || bus.en_x !== 44'd0 || bus.en_y !== 44'd0 ||
        {bus.alive, bus.level, bus.pos_valid, bus.level_done, bus.game_won, bus.busy} !== 12'd0) begin
      failures++;
      $display("FAIL fetch_reset: got addr=%0d x=%0h y=%0h alive=%0h level=%0d busy=%0b, required all 0",
               bus.rom_addr, bus.en_x, bus.en_y, bus.alive, bus.level, bus.busy);
    end
    repeat (20) tick();
    assertions++;
    if (bus.busy !== 1'b0 || bus.level !== 4'd0 || bus.rom_addr !== 12'd0 || bus.pos_valid !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_idle: got busy=%0b level=%0d addr=%0d pos_valid=%0b, required 0/0/0/0",
               bus.busy, bus.level, bus.rom_addr, bus.pos_valid);
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.kill  = 4'd0;
    test_reset();
    test_first_fetch();
    test_wrap();
    test_kill_during_fetch();
    test_start_ignored();
    test_level_up();
    test_won();
    test_reset_in_fetch();
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule

// File: doc/enemy_wave_ctrl.md
ENEMY_WAVE_CTRL -- requirements
Module: enemy_wave_ctrl

Interface
REQ-001 Parameters: TICK_LIMIT, 1000000, pclk cycles per path step; LEVEL_SCALER, 150, path ROM entries per level; SPACING, 30, path offset between adjacent enemies; MAX_LEVEL, 2, last playable level.
REQ-002 pclk  in  1  clock; all state SHALL change on its rising edge only.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 start  in  1  one-cycle pulse; begins a game at level 1.
REQ-005 kill  in  4  bit k high = enemy k hit this cycle.
REQ-006 rom_addr  out  12  shared path ROM address, registered.
REQ-007 rom_x, rom_y  in  12 each  ROM data; valid exactly 1 cycle after rom_addr changes.
REQ-008 en_x, en_y  out  44 each  packed positions; enemy k at bits [11k+10:11k].
REQ-009 alive  out  4  bit k high = enemy k alive.
REQ-010 level  out  4  current level, 0 when idle.
REQ-011 pos_valid, level_done, game_won  out  1 each  one-cycle pulses.
REQ-012 busy  out  1  high in any state other than IDLE and WON.

Function
REQ-013 FSM states: IDLE, RUN, FETCH, LEVEL_UP, WON.
REQ-014 IDLE: start -> RUN; level=1, alive=4'b1111, off=0, tick counter=0.
REQ-015 RUN: tick counter increments each cycle; at counter==TICK_LIMIT-1, counter -> 0 and state -> FETCH.
REQ-016 RUN: if alive==0, state -> LEVEL_UP the next cycle; this check SHALL take priority over the tick.
REQ-017 Enemy k path address = LEVEL_SCALER*(level-1) + ((off + k*SPACING) mod LEVEL_SCALER); the mod SHALL be done as a single conditional subtract, valid because 3*SPACING < LEVEL_SCALER.
REQ-018 FETCH SHALL last exactly 5 cycles, F0..F4:
- Fi (i<4): drive rom_addr for enemy i.
- Fi (i>=1): capture rom_x[10:0], rom_y[10:0] into the enemy i-1 slot.
REQ-019 Fetch outcome: all 4 slots SHALL be fetched regardless of alive; slots not being captured hold their value.
REQ-020 Exit F4:
- off <= off+1, wrapping LEVEL_SCALER-1 -> 0;
- pos_valid high for 1 cycle in the first RUN cycle;
- state -> RUN.
REQ-021 kill[k] SHALL clear alive[k] on the next edge in RUN or FETCH; kill on a dead enemy, or in other states, SHALL be ignored.
REQ-022 Kill during FETCH: the fetch SHALL complete unchanged; alive==0 is evaluated in the next RUN cycle.
REQ-023 LEVEL_UP (1 cycle), if level<MAX_LEVEL:
- level+1, alive=4'b1111, off=0, counter=0;
- level_done pulse;
- state -> RUN.
REQ-024 LEVEL_UP, if level==MAX_LEVEL: game_won pulse, state -> WON; level, alive and positions held.
REQ-025 WON: start SHALL restart exactly as REQ-014.
REQ-026 start SHALL be ignored in RUN, FETCH and LEVEL_UP.
REQ-027 Widths: off 8-bit; counter 21-bit; address sum computed at 12 bits; rom bit 11 discarded.

Reset
REQ-028 rst SHALL force:
- state IDLE;
- level, alive, off, counter, rom_addr, en_x, en_y all 0;
- all pulses low.
REQ-029 rst SHALL override start, kill and any in-progress FETCH in the same cycle.

Verification (TICK_LIMIT=10, ROM x[a]=a, y[a]=a+512)
REQ-030 start -> busy=1, level=1, alive=4'hF; 10 cycles later rom_addr sequence 0, 30, 60, 90; then en_x slots 0/1/2/3 = 0/30/60/90, en_y = 512/542/572/602, one pos_valid pulse.
REQ-031 Run 150 ticks at level 1 -> enemy 0 addresses run 0..149 and wrap to 0; enemy 3 at off=60 reads address 0 (60+90-150).
REQ-032 kill=4'hF in one RUN cycle -> alive=0, LEVEL_UP; level=2, level_done pulse; next fetch addresses 150, 180, 210, 240.
REQ-033 kill=4'b0010 during F2, repeated at F3 -> fetch completes all 4 slots; alive=4'hD; no effect from the repeat.
REQ-034 Level 2, all enemies killed -> game_won pulse, state WON, busy=0, level=2; start -> level=1, alive=4'hF.
REQ-035 rst asserted at F2 -> next cycle all outputs 0, state IDLE; a start issued in the same cycle as rst is ignored.
